// File: rtl/traffic_light_seq.sv
// traffic_light_seq: RED/GREEN/YELLOW phase sequencer with pedestrian
// shortening and a RED/WHITE flash mode, feeding the colour mapper.
`timescale 1ns/1ps
module traffic_light_seq #(
  parameter int TICK_DIV  = 50000000,
  parameter int RED_T     = 8,
  parameter int GREEN_T   = 10,
  parameter int YELLOW_T  = 3,
  parameter int MIN_GREEN = 3
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       i_enable,
  input  logic       i_ped_req,
  input  logic       i_fault,
  output logic [1:0] o_signal,
  output logic [7:0] o_remain,
  output logic       o_ped_ack,
  output logic       o_tick
);

  localparam int PW = $clog2(TICK_DIV);

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] RED_L = 8'(RED_T - 1);
  localparam logic [7:0] GRN_L = 8'(GREEN_T - 1);
  localparam logic [7:0] YEL_L = 8'(YELLOW_T - 1);
  localparam logic [7:0] MG_L  = 8'(MIN_GREEN - 1);

  typedef enum logic [1:0] {
    S_RED,
    S_GREEN,
    S_YELLOW,
    S_FLASH
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ped_q, ped_d;
  logic          flash_q, flash_d;
  logic          ack_q, ack_d;
  logic          en_q;

  logic tick;
  logic last;
  logic ped_eff;

  // Enable is registered so o_tick stays a pure decode of flops.
  assign tick = en_q && (presc_q == P_LAST);
  assign last = (cnt_q == 8'd0);

  assign ped_eff = ped_q |
    (i_ped_req &
     ((state_q == S_GREEN) | (state_q == S_YELLOW)));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_RED;
      cnt_q   <= RED_L;
      presc_q <= '0;
      ped_q   <= 1'b0;
      flash_q <= 1'b0;
      ack_q   <= 1'b0;
      en_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      ped_q   <= ped_d;
      flash_q <= flash_d;
      ack_q   <= ack_d;
      en_q    <= i_enable;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    ped_d   = ped_q;
    flash_d = flash_q;
    ack_d   = 1'b0;
    if (i_fault) begin
      state_d = S_FLASH;
      ped_d   = 1'b0;
      if (state_q != S_FLASH) begin
        presc_d = '0;
        flash_d = 1'b0;
      end else if (tick) begin
        presc_d = '0;
        flash_d = ~flash_q;
      end else if (en_q) begin
        presc_d = presc_q + PW'(1);
      end
    end else if (state_q == S_FLASH) begin
      state_d = S_RED;
      cnt_d   = RED_L;
      presc_d = '0;
      flash_d = 1'b0;
    end else if (en_q) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      ped_d   = ped_eff;
      unique case (state_q)
        S_RED: begin
          if (tick && last) begin
            state_d = S_GREEN;
            cnt_d   = GRN_L;
          end else if (tick) begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_GREEN: begin
          if (tick && last) begin
            state_d = S_YELLOW;
            cnt_d   = YEL_L;
          end else if (ped_eff && (cnt_q > MG_L)) begin
            // Restart the prescaler so exactly MIN_GREEN full ticks remain.
            cnt_d   = MG_L;
            presc_d = '0;
          end else if (tick) begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_YELLOW: begin
          if (tick && last) begin
            state_d = S_RED;
            cnt_d   = RED_L;
            ack_d   = ped_eff;
            ped_d   = 1'b0;
          end else if (tick) begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    o_signal = 2'b00;
    unique case (1'b1)
      state_q == S_GREEN:  o_signal = 2'b10;
      state_q == S_YELLOW: o_signal = 2'b01;
      state_q == S_FLASH:  o_signal = {flash_q, flash_q};
      default:             o_signal = 2'b00;
    endcase
  end

  assign o_remain  = (state_q == S_FLASH) ? 8'd0 : cnt_q + 8'd1;
  assign o_ped_ack = ack_q;
  assign o_tick    = tick;

endmodule
